// File: rtl/approx_err_sweep_ctrl.sv
// Exhaustive error sweep of an approximate circuit against its exact twin.
// Ports: clk, rst_n, start, vec, approx_out, exact_out, busy, done, pass,
// max_err, err_count, first_fail_vec. Option: APPROX_SWEEP_EARLY_ABORT_EN.
module approx_err_sweep_ctrl #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int ET    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  vec,
  input  logic [N_OUT-1:0] approx_out,
  input  logic [N_OUT-1:0] exact_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] max_err,
  output logic [N_IN:0]    err_count,
  output logic [N_IN-1:0]  first_fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [N_OUT-1:0] ET_V  = N_OUT'(ET);
  localparam logic [N_IN-1:0]  LAST  = '1;
  localparam logic [N_IN-1:0]  ONE_V = N_IN'(1);
  localparam logic [N_IN:0]    ONE_C = (N_IN+1)'(1);

  state_t             state;
  logic               fail;
  logic [N_OUT:0]     diff;
  logic [N_OUT:0]     neg;
  logic [N_OUT-1:0]   err;
  logic [N_OUT-1:0]   new_max;
  logic               over;
  logic               stop;

  // One extra bit holds the sign of the difference.
  always_comb begin
    diff    = {1'b0, exact_out} - {1'b0, approx_out};
    neg     = ~diff + 1'b1;
    err     = diff[N_OUT] ? neg[N_OUT-1:0] : diff[N_OUT-1:0];
    new_max = (err > max_err) ? err : max_err;
    over    = (err > ET_V);
`ifdef APPROX_SWEEP_EARLY_ABORT_EN
    stop    = (vec == LAST) || over;
`else
    stop    = (vec == LAST);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      max_err        <= '0;
      err_count      <= '0;
      first_fail_vec <= '0;
      fail           <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            max_err        <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
            fail           <= 1'b0;
            pass           <= 1'b0;
            vec            <= '0;
            busy           <= 1'b1;
            state          <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          max_err <= new_max;
          if (err != '0) begin
            err_count <= err_count + ONE_C;
          end
          if (over && !fail) begin
            first_fail_vec <= vec;
            fail           <= 1'b1;
          end
          if (stop) begin
            done  <= 1'b1;
            pass  <= (new_max <= ET_V);
            state <= S_DONE;
          end else begin
            vec   <= vec + ONE_V;
            state <= S_DRIVE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          vec   <= '0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_err_sweep_ctrl.sv
// Bench for approx_err_sweep_ctrl: a sweep-level model predicts the
// per-cycle vec/busy/done timeline and the final error statistics.
module tb_approx_err_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] vec;
  logic [2:0] approx_out;
  logic [2:0] exact_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] max_err;
  logic [4:0] err_count;
  logic [3:0] first_fail_vec;

  int errors = 0;
  int checks = 0;
  int ph = 0;
  int bias = 2;
  logic [2:0] approx_tab [16];

  int m_max, m_cnt, m_ffv, m_pass, m_last;
  int l2, ev, eb, ed;

  approx_err_sweep_ctrl #(.N_IN(4), .N_OUT(3), .ET(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .vec(vec),
    .approx_out(approx_out),
    .exact_out(exact_out),
    .busy(busy),
    .done(done),
    .pass(pass),
    .max_err(max_err),
    .err_count(err_count),
    .first_fail_vec(first_fail_vec)
  );

  always #5 clk = ~clk;

  // Exact circuit: 2-bit + 2-bit adder with a bias, modulo 8.
  always_comb begin
    exact_out  = 3'(int'(vec[1:0]) + int'(vec[3:2]) + bias);
    approx_out = approx_tab[vec];
  end

  function automatic int exact_f(input int v);
    return (v % 4 + v / 4 + bias) % 8;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (ph=%0d)", nm, act, exp, ph);
    end
  endtask

  task automatic set_tab(input int kind);
    for (int v = 0; v < 16; v++) begin
      int e;
      e = exact_f(v);
      case (kind)
        1: if (v == 5) e = e ^ 4;
        2: if (v == 2 || v == 9) e = e - 3;
        3: if (v == 3 || v == 12) e = e - 5;
        4: if (v == 4) e = e + 6;
        default: ;
      endcase
      approx_tab[v] = 3'(e);
    end
  endtask

  task automatic model_sweep();
    int fl;
    m_max = 0; m_cnt = 0; m_ffv = 0; m_last = 15; fl = 0;
    for (int v = 0; v < 16; v++) begin
      int e;
      e = exact_f(v) - int'(approx_tab[v]);
      if (e < 0) e = -e;
      if (e > m_max) m_max = e;
      if (e != 0) m_cnt++;
      if (e > 3 && fl == 0) begin
        m_ffv = v;
        fl = 1;
`ifdef APPROX_SWEEP_EARLY_ABORT_EN
        m_last = v;
        break;
`endif
      end
    end
    m_pass = (m_max <= 3) ? 1 : 0;
  endtask

  // Timeline compare: vector k is driven for edges 2k+1 and 2k+2.
  always @(negedge clk) begin
    if (ph > 0) begin
      l2 = 2 * (m_last + 1);
      if (ph <= l2) begin
        ev = (ph - 1) / 2; eb = 1; ed = 0;
      end else if (ph == l2 + 1) begin
        ev = m_last; eb = 1; ed = 1;
      end else begin
        ev = 0; eb = 0; ed = 0;
      end
      chk("vec", vec, ev);
      chk("busy", busy, eb);
      chk("done", done, ed);
      if (ph == 1) begin
        chk("clr max_err", max_err, 0);
        chk("clr err_count", err_count, 0);
        chk("clr first_fail_vec", first_fail_vec, 0);
      end
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, " vec"}, vec, 0);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " pass"}, pass, 0);
    chk({nm, " max_err"}, max_err, 0);
    chk({nm, " err_count"}, err_count, 0);
    chk({nm, " first_fail_vec"}, first_fail_vec, 0);
  endtask

  task automatic run_sweep(input int rst_at, input bit poke);
    model_sweep();
    @(negedge clk) start = 1'b1;
    @(posedge clk) ph = 1;
    @(negedge clk) start = 1'b0;
    for (int i = 2; i <= 2 * (m_last + 1) + 2; i++) begin
      @(posedge clk) ph = i;
      @(negedge clk);
      start = poke && (i == 5 || i == 20 || i == 31);
      if (i == rst_at) begin
        start = 1'b0;
        #1 rst_n = 1'b0;
        ph = 0;
        #1 check_zero("mid_rst");
        @(negedge clk) check_zero("mid_rst_hold");
        rst_n = 1'b1;
        return;
      end
    end
    start = 1'b0;
    chk("res max_err", max_err, m_max);
    chk("res err_count", err_count, m_cnt);
    chk("res first_fail_vec", first_fail_vec, m_ffv);
    chk("res pass", pass, m_pass);
    ph = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bias  = 2;
    set_tab(0);
    repeat (3) @(posedge clk);
    @(negedge clk) check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk) check_zero("post_reset");

    set_tab(0);
    run_sweep(0, 1'b0);
    chk("t1 max_err", max_err, 0);
    chk("t1 pass", pass, 1);

    set_tab(1);
    run_sweep(0, 1'b0);
    chk("t2 max_err", max_err, 4);
    chk("t2 err_count", err_count, 1);
    chk("t2 first_fail_vec", first_fail_vec, 5);
    chk("t2 pass", pass, 0);

    set_tab(2);
    run_sweep(0, 1'b0);
    chk("t3 max_err", max_err, 3);
    chk("t3 err_count", err_count, 2);
    chk("t3 first_fail_vec", first_fail_vec, 0);
    chk("t3 pass", pass, 1);

    set_tab(3);
    for (int r = 0; r < 2; r++) begin
      run_sweep(0, 1'b0);
      chk("t4 max_err", max_err, 5);
`ifdef APPROX_SWEEP_EARLY_ABORT_EN
      chk("t4 err_count", err_count, 1);
`else
      chk("t4 err_count", err_count, 2);
`endif
      chk("t4 first_fail_vec", first_fail_vec, 3);
      chk("t4 pass", pass, 0);
      repeat (2) @(negedge clk);
    end

    set_tab(2);
    run_sweep(16, 1'b0);
    set_tab(0);
    run_sweep(0, 1'b1);
    chk("t5 err_count", err_count, 0);
    chk("t5 pass", pass, 1);

`ifdef APPROX_SWEEP_EARLY_ABORT_EN
    bias = 0;
    set_tab(4);
    run_sweep(0, 1'b0);
    chk("ab max_err", max_err, 6);
    chk("ab err_count", err_count, 1);
    chk("ab first_fail_vec", first_fail_vec, 4);
    chk("ab pass", pass, 0);
    chk("ab last", m_last, 4);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
